// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and helpers for the LTC2308 scan sequencer
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_CONV_WAIT,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Bit positions inside the 6-bit LTC2308 config word (bit 5 goes out first)
    localparam int CFG_SD_POS  = 5;
    localparam int CFG_OS_POS  = 4;
    localparam int CFG_S1_POS  = 3;
    localparam int CFG_S0_POS  = 2;
    localparam int CFG_UNI_POS = 1;
    localparam int CFG_SLP_POS = 0;

    localparam logic CFG_SD  = 1'b1;
    localparam logic CFG_UNI = 1'b1;
    localparam logic CFG_SLP = 1'b0;

    function automatic logic [5:0] cfg_word(input logic [2:0] ch);
        logic [5:0] w;
        w              = '0;
        w[CFG_SD_POS]  = CFG_SD;
        w[CFG_OS_POS]  = ch[0];
        w[CFG_S1_POS]  = ch[2];
        w[CFG_S0_POS]  = ch[1];
        w[CFG_UNI_POS] = CFG_UNI;
        w[CFG_SLP_POS] = CFG_SLP;
        return w;
    endfunction

    // Lowest set bit above cur; falls back to the lowest set bit overall.
    function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] nxt;
        nxt = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) nxt = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) nxt = 3'(i);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/adc_spi_shift.sv
// rtl/adc_spi_shift.sv - 12-bit SCK generator and shifter, SCK idles low
module adc_spi_shift #(
    parameter int SCK_HALF = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] tx_cfg,
    input  logic        sdo,
    output logic        done,
    output logic [11:0] rx_data,
    output logic        sck,
    output logic        sdi
);

    logic        active;
    logic [15:0] half_cnt;
    logic [3:0]  bit_idx;
    logic [11:0] tx_sr;
    logic [11:0] rx_sr;
    logic        half_end;

    assign half_end = active && (half_cnt == 16'(SCK_HALF - 1));
    assign done     = half_end && sck && (bit_idx == 4'd11);
    assign rx_data  = rx_sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            half_cnt <= '0;
            bit_idx  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sck      <= 1'b0;
            sdi      <= 1'b0;
        end else if (start) begin
            active   <= 1'b1;
            half_cnt <= '0;
            bit_idx  <= '0;
            sck      <= 1'b0;
            sdi      <= tx_cfg[11];
            tx_sr    <= {tx_cfg[10:0], 1'b0};
        end else if (active) begin
            if (half_end) begin
                half_cnt <= '0;
                if (!sck) begin
                    sck   <= 1'b1;
                    rx_sr <= {rx_sr[10:0], sdo};
                end else begin
                    sck <= 1'b0;
                    if (done) begin
                        active <= 1'b0;
                        sdi    <= 1'b0;
                    end else begin
                        // next config bit is presented as the low phase begins
                        bit_idx <= bit_idx + 4'd1;
                        sdi     <= tx_sr[11];
                        tx_sr   <= {tx_sr[10:0], 1'b0};
                    end
                end
            end else begin
                half_cnt <= half_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin LTC2308 scan controller with result stream
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int SCK_HALF      = 2,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int GAP_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  res_channel,
    output logic [11:0] res_data,
    output logic        busy,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [2:0]  cur_ch;
    logic [2:0]  prev_ch;
    logic        dummy;
    logic        spi_start;
    logic        spi_done;
    logic [11:0] rx_data;
    logic        scan_ok;

    assign scan_ok    = enable && (|ch_mask);
    assign busy       = (state != ST_IDLE);
    assign adc_convst = (state == ST_CONVST);

    adc_spi_shift #(
        .SCK_HALF (SCK_HALF)
    ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (spi_start),
        .tx_cfg  ({cfg_word(cur_ch), 6'b000000}),
        .sdo     (adc_sdo),
        .done    (spi_done),
        .rx_data (rx_data),
        .sck     (adc_sck),
        .sdi     (adc_sdi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        spi_start  = 1'b0;
        unique case (state)
            ST_IDLE:      if (scan_ok) state_next = ST_CONVST;
            ST_CONVST:    if (cnt == 16'(CONVST_CYCLES - 1)) state_next = ST_CONV_WAIT;
            ST_CONV_WAIT: if (cnt == 16'(CONV_CYCLES - 1)) begin
                              state_next = ST_SHIFT;
                              spi_start  = 1'b1;
                          end
            ST_SHIFT:     if (spi_done) state_next = dummy ? ST_GAP : ST_HOLD;
            ST_HOLD:      if (res_ready) state_next = ST_GAP;
            ST_GAP:       if (cnt == 16'(GAP_CYCLES - 1)) state_next = scan_ok ? ST_CONVST : ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            cur_ch      <= '0;
            prev_ch     <= '0;
            dummy       <= 1'b0;
            res_valid   <= 1'b0;
            res_channel <= '0;
            res_data    <= '0;
        end else begin
            if (state_next != state)
                cnt <= '0;
            else if (state == ST_CONVST || state == ST_CONV_WAIT || state == ST_GAP)
                cnt <= cnt + 16'd1;

            if (state == ST_IDLE && state_next == ST_CONVST) begin
                cur_ch <= next_ch(ch_mask, 3'd7);
                dummy  <= 1'b1;
            end
            if (state == ST_GAP && state_next == ST_CONVST)
                cur_ch <= next_ch(ch_mask, cur_ch);

            // the sample just shifted in was converted with the previous frame's config
            if (state == ST_SHIFT && spi_done) begin
                prev_ch <= cur_ch;
                dummy   <= 1'b0;
                if (!dummy) begin
                    res_valid   <= 1'b1;
                    res_channel <= prev_ch;
                    res_data    <= rx_data;
                end
            end
            if (state == ST_HOLD && res_ready)
                res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed self-checking bench with an LTC2308 behavioural model
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        res_ready = 1'b1;
    logic        res_valid;
    logic [2:0]  res_channel;
    logic [11:0] res_data;
    logic        busy;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo = 1'b0;

    int checks = 0;
    int failures = 0;

    adc_scan_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_channel (res_channel),
        .res_data    (res_data),
        .busy        (busy),
        .adc_convst  (adc_convst),
        .adc_sck     (adc_sck),
        .adc_sdi     (adc_sdi),
        .adc_sdo     (adc_sdo)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ADC model: decodes config from SDI, returns a code for the previously configured channel
    bit          const_mode = 1'b1;
    logic [11:0] sdi_sr = '0;
    int          sdi_bits = 0;
    logic [11:0] sdi_words[$];
    logic [2:0]  last_cfg_ch = '0;
    logic [11:0] sdo_word = '0;
    int          sdo_idx = -1;

    always @(posedge adc_convst or adc_sck) begin
        if (adc_convst) begin
            sdi_bits = 0;
            sdo_word = const_mode ? 12'hA5C : (12'h100 + {9'd0, last_cfg_ch});
            adc_sdo  = sdo_word[11];
            sdo_idx  = 10;
        end else if (adc_sck) begin
            sdi_sr = {sdi_sr[10:0], adc_sdi};
            sdi_bits++;
            if (sdi_bits == 12) begin
                sdi_words.push_back(sdi_sr);
                last_cfg_ch = {sdi_sr[9], sdi_sr[8], sdi_sr[10]};
                sdi_bits = 0;
            end
        end else begin
            if (sdo_idx >= 0) begin
                adc_sdo = sdo_word[sdo_idx];
                sdo_idx--;
            end else begin
                adc_sdo = 1'b0;
            end
        end
    end

    logic [2:0]  res_ch_q[$];
    logic [11:0] res_data_q[$];
    int          conv_stamp[$];
    int          conv_cnt = 0;
    logic        convst_d = 1'b0;

    always @(negedge clk) begin
        if (reset_n && res_valid && res_ready) begin
            res_ch_q.push_back(res_channel);
            res_data_q.push_back(res_data);
        end
        if (adc_convst && !convst_d) begin
            conv_stamp.push_back(cyc);
            conv_cnt++;
        end
        convst_d = adc_convst;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_conv(input int n, input int budget, input string tag);
        int k = 0;
        while (conv_cnt < n && k < budget) begin tick(1); k++; end
        chk(tag, 32'(conv_cnt >= n), 32'd1);
    endtask

    task automatic wait_res(input int n, input int budget, input string tag);
        int k = 0;
        while (res_ch_q.size() < n && k < budget) begin tick(1); k++; end
        chk(tag, 32'(res_ch_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin tick(1); k++; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int cb, rb, sb, c0, r0;
        logic [11:0] d0;
        bit stable;
        logic [2:0]  exp_ch[5];
        exp_ch[0] = 3'd0; exp_ch[1] = 3'd2; exp_ch[2] = 3'd5; exp_ch[3] = 3'd0; exp_ch[4] = 3'd2;

        tick(3);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_convst", 32'(adc_convst), 32'd0);
        chk("rst_sck", 32'(adc_sck), 32'd0);
        chk("rst_sdi", 32'(adc_sdi), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // single channel 0, constant code
        const_mode = 1'b1;
        ch_mask = 8'h01;
        cb = conv_cnt; rb = res_ch_q.size(); sb = sdi_words.size();
        enable = 1'b1;
        chk("c1_convst_before", 32'(adc_convst), 32'd0);
        tick(1);
        chk("c1_convst_first", 32'(adc_convst), 32'd1);
        wait_conv(cb + 2, 400, "c1_wait_conv2");
        chk("c1_dummy_no_result", 32'(res_ch_q.size()), 32'(rb));
        wait_conv(cb + 4, 600, "c1_wait_conv4");
        chk("c1_res_count", 32'(res_ch_q.size()), 32'(rb + 2));
        chk("c1_res0_ch", 32'(res_ch_q[rb]), 32'd0);
        chk("c1_res0_data", 32'(res_data_q[rb]), 32'hA5C);
        chk("c1_res1_data", 32'(res_data_q[rb + 1]), 32'hA5C);
        chk("c1_sdi0", 32'(sdi_words[sb]), 32'h880);
        chk("c1_sdi1", 32'(sdi_words[sb + 1]), 32'h880);
        chk("c1_sdi2", 32'(sdi_words[sb + 2]), 32'h880);
        enable = 1'b0;
        wait_idle(300, "c1_idle");

        // mask 0x25, model returns 0x100 + channel
        const_mode = 1'b0;
        ch_mask = 8'h25;
        cb = conv_cnt; rb = res_ch_q.size();
        enable = 1'b1;
        wait_res(rb + 5, 1200, "c2_wait_res");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("c2_res%0d_ch", i), 32'(res_ch_q[rb + i]), 32'(exp_ch[i]));
            chk($sformatf("c2_res%0d_data", i), 32'(res_data_q[rb + i]), 32'h100 + 32'(exp_ch[i]));
        end
        chk("c2_period", 32'(conv_stamp[cb + 2] - conv_stamp[cb + 1]), 32'd135);
        chk("c2_period_b", 32'(conv_stamp[cb + 3] - conv_stamp[cb + 2]), 32'd135);
        enable = 1'b0;
        wait_idle(300, "c2_idle");

        // config words for ch3 and ch6
        ch_mask = 8'h48;
        cb = conv_cnt; sb = sdi_words.size();
        enable = 1'b1;
        wait_conv(cb + 3, 500, "c3_wait_conv");
        chk("c3_sdi_ch3", 32'(sdi_words[sb]), 32'hD80);
        chk("c3_sdi_ch6", 32'(sdi_words[sb + 1]), 32'hB80);

        // stall the sink for 500 cycles
        res_ready = 1'b0;
        begin
            int k = 0;
            while (!res_valid && k < 300) begin tick(1); k++; end
        end
        chk("c4_valid_seen", 32'(res_valid), 32'd1);
        c0 = conv_cnt; d0 = res_data; stable = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (res_data !== d0 || res_valid !== 1'b1) stable = 1'b0;
        end
        chk("c4_no_convst", 32'(conv_cnt), 32'(c0));
        chk("c4_stable", 32'(stable), 32'd1);
        r0 = res_ch_q.size();
        res_ready = 1'b1;
        tick(1);
        chk("c4_valid_drop", 32'(res_valid), 32'd0);
        chk("c4_one_result", 32'(res_ch_q.size()), 32'(r0 + 1));
        tick(3);
        chk("c4_gap_low", 32'(adc_convst), 32'd0);
        tick(1);
        chk("c4_convst_rise", 32'(adc_convst), 32'd1);

        // drop enable during CONV_WAIT
        tick(5);
        r0 = res_ch_q.size(); c0 = conv_cnt;
        enable = 1'b0;
        wait_idle(300, "c5_idle");
        chk("c5_result_delivered", 32'(res_ch_q.size()), 32'(r0 + 1));
        tick(200);
        chk("c5_no_more_convst", 32'(conv_cnt), 32'(c0));
        chk("c5_busy_low", 32'(busy), 32'd0);

        // reset mid-SHIFT
        const_mode = 1'b1;
        ch_mask = 8'h01;
        cb = conv_cnt;
        enable = 1'b1;
        wait_conv(cb + 2, 400, "c6_wait_conv");
        begin
            int k = 0;
            while (!adc_sck && k < 300) begin tick(1); k++; end
        end
        chk("c6_in_shift", 32'(adc_sck), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("c6_rst_sck", 32'(adc_sck), 32'd0);
        chk("c6_rst_sdi", 32'(adc_sdi), 32'd0);
        chk("c6_rst_convst", 32'(adc_convst), 32'd0);
        chk("c6_rst_valid", 32'(res_valid), 32'd0);
        chk("c6_rst_busy", 32'(busy), 32'd0);
        tick(1);
        reset_n = 1'b1;
        cb = conv_cnt; r0 = res_ch_q.size();
        wait_conv(cb + 2, 400, "c6_wait_conv_after");
        chk("c6_dummy_no_result", 32'(res_ch_q.size()), 32'(r0));
        wait_res(r0 + 1, 300, "c6_wait_res");
        chk("c6_res_ch", 32'(res_ch_q[r0]), 32'd0);
        chk("c6_res_data", 32'(res_data_q[r0]), 32'hA5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
